// File: rtl/calc_sched_pkg.sv
// Shared types and defaults for the calc_new_parameters axis scheduler.
package calc_sched_pkg;

  localparam int unsigned N_AXES_DEF   = 5;
  localparam int unsigned N_PARAMS_DEF = 5;
  localparam int unsigned WIDTH_DEF    = 32;

  localparam int unsigned AX_X  = 0;
  localparam int unsigned AX_Y  = 1;
  localparam int unsigned AX_Z  = 2;
  localparam int unsigned AX_E0 = 3;
  localparam int unsigned AX_E1 = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FIN = 2'd1,
    GAP      = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/calc_sched_next_axis.sv
// Priority finder: lowest enabled axis above base (or at base when inclusive).
module calc_sched_next_axis
  import calc_sched_pkg::*;
#(
  parameter int unsigned N_AXES = N_AXES_DEF,
  localparam int unsigned AXW   = idx_w(N_AXES)
) (
  input  logic [N_AXES-1:0] mask,
  input  logic [AXW-1:0]    base,
  input  logic              inclusive,
  output logic [AXW-1:0]    idx_c,
  output logic              none_c
);

  // Scan downwards so the lowest qualifying index is the last one written.
  always_comb begin
    idx_c  = '0;
    none_c = 1'b1;
    for (int i = int'(N_AXES) - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(base)) || (inclusive && (i == int'(base))))) begin
        idx_c  = AXW'(i);
        none_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_params_scheduler.sv
// Time-shares one external parameter calculator across N_AXES parameter sets,
// issuing enabled axes in ascending order with a level start/finish handshake.
module calc_params_scheduler
  import calc_sched_pkg::*;
#(
  parameter int unsigned N_AXES     = N_AXES_DEF,
  parameter int unsigned N_PARAMS   = N_PARAMS_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned GAP_CYCLES = 20,
  parameter int unsigned TIMEOUT    = 65535,
  localparam int unsigned AXW       = idx_w(N_AXES)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [N_AXES-1:0]                        axis_en,
  input  logic [N_AXES-1:0][N_PARAMS-1:0][WIDTH-1:0] params,
  output logic                                     cu_start,
  output logic [N_PARAMS-1:0][WIDTH-1:0]           cu_params,
  input  logic                                     cu_finish,
  input  logic [N_PARAMS-1:0][WIDTH-1:0]           cu_new_par,
  output logic [N_AXES-1:0][N_PARAMS-1:0][WIDTH-1:0] new_par,
  output logic                                     busy,
  output logic                                     finish,
  output logic                                     done,
  output logic [N_AXES-1:0]                        axis_done,
  output logic [N_AXES-1:0]                        axis_err,
  output logic [AXW-1:0]                           cur_axis
);

  localparam int unsigned TW = idx_w(TIMEOUT + 1);
  localparam int unsigned GW = idx_w(GAP_CYCLES + 1);

  state_t          state_q, state_d;
  logic [N_AXES-1:0] en_q, en_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic                                      cu_start_d;
  logic [N_PARAMS-1:0][WIDTH-1:0]            cu_params_d;
  logic [N_AXES-1:0][N_PARAMS-1:0][WIDTH-1:0] new_par_d;
  logic                                      busy_d, finish_d, done_d;
  logic [N_AXES-1:0]                         axis_done_d, axis_err_d;
  logic [AXW-1:0]                            cur_axis_d;

  logic [N_AXES-1:0] find_mask;
  logic [AXW-1:0]    find_base;
  logic              find_incl;
  logic [AXW-1:0]    nx_idx;
  logic              nx_none;
  logic              timeout_c;

  // In IDLE the first axis comes from the live enables; afterwards from the latched mask.
  assign find_mask = (state_q == IDLE) ? axis_en : en_q;
  assign find_base = (state_q == IDLE) ? '0 : cur_axis;
  assign find_incl = (state_q == IDLE);

  calc_sched_next_axis #(.N_AXES(N_AXES)) u_next (
    .mask      (find_mask),
    .base      (find_base),
    .inclusive (find_incl),
    .idx_c     (nx_idx),
    .none_c    (nx_none)
  );

  assign timeout_c = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      en_q      <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      cu_start  <= 1'b0;
      cu_params <= '0;
      new_par   <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
      done      <= 1'b0;
      axis_done <= '0;
      axis_err  <= '0;
      cur_axis  <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      cu_start  <= cu_start_d;
      cu_params <= cu_params_d;
      new_par   <= new_par_d;
      busy      <= busy_d;
      finish    <= finish_d;
      done      <= done_d;
      axis_done <= axis_done_d;
      axis_err  <= axis_err_d;
      cur_axis  <= cur_axis_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    cu_start_d  = cu_start;
    cu_params_d = cu_params;
    new_par_d   = new_par;
    busy_d      = busy;
    finish_d    = finish;
    done_d      = 1'b0;
    axis_done_d = axis_done;
    axis_err_d  = axis_err;
    cur_axis_d  = cur_axis;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          en_d        = axis_en;
          axis_done_d = '0;
          axis_err_d  = '0;
          for (int a = 0; a < int'(N_AXES); a++) begin
            if (!axis_en[a]) new_par_d[a] = params[a];
          end
          if (nx_none) begin
            state_d  = DONE;
            finish_d = 1'b1;
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end else begin
            busy_d      = 1'b1;
            cur_axis_d  = nx_idx;
            cu_params_d = params[nx_idx];
            cu_start_d  = 1'b1;
            timer_d     = '0;
            state_d     = WAIT_FIN;
          end
        end
      end

      WAIT_FIN: begin
        if (!start) begin
          state_d    = IDLE;
          cu_start_d = 1'b0;
          busy_d     = 1'b0;
        end else if (cu_finish || timeout_c) begin
          // A result arriving on the expiry cycle still counts as a success.
          cu_start_d = 1'b0;
          gap_d      = '0;
          if (cu_finish) begin
            new_par_d[cur_axis]   = cu_new_par;
            axis_done_d[cur_axis] = 1'b1;
          end else begin
            axis_err_d[cur_axis] = 1'b1;
          end
          if (nx_none) begin
            state_d  = DONE;
            finish_d = 1'b1;
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end else begin
            state_d = GAP;
          end
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end

      GAP: begin
        if (!start) begin
          state_d    = IDLE;
          cu_start_d = 1'b0;
          busy_d     = 1'b0;
        end else if ((gap_q == GW'(GAP_CYCLES)) && !cu_finish) begin
          cur_axis_d  = nx_idx;
          cu_params_d = params[nx_idx];
          cu_start_d  = 1'b1;
          timer_d     = '0;
          state_d     = WAIT_FIN;
        end else if (gap_q != GW'(GAP_CYCLES)) begin
          gap_d = gap_q + GW'(1);
        end
      end

      DONE: begin
        if (!start) begin
          state_d  = IDLE;
          finish_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_calc_params_scheduler.sv
// Directed bench: a slow instance (default gap/timeout) and a fast one (gap 0, timeout 8).
module tb_calc_params_scheduler;

  localparam int unsigned NA  = 5;
  localparam int unsigned NP  = 5;
  localparam int unsigned W   = 32;
  localparam int unsigned AXW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]                         start_v;
  logic [NA-1:0]                      axis_en;
  logic [NA-1:0][NP-1:0][W-1:0]       params;
  logic [1:0]                         cu_start_v, cu_finish_v, busy_v, finish_v, done_v;
  logic [1:0][NP-1:0][W-1:0]          cu_params_v, cu_new_par_v;
  logic [1:0][NA-1:0][NP-1:0][W-1:0]  new_par_v, exp_np;
  logic [1:0][NA-1:0]                 axis_done_v, axis_err_v;
  logic [1:0][AXW-1:0]                cur_axis_v, mute_ax_v;
  logic [1:0]                         mute_v;
  int                                 hold_v [2];
  int                                 m_cnt  [2];
  int                                 m_hold [2];

  int n_checks = 0;
  int n_fail   = 0;

  calc_params_scheduler #(.N_AXES(NA), .N_PARAMS(NP), .WIDTH(W),
                          .GAP_CYCLES(20), .TIMEOUT(65535)) u_slow (
    .clk(clk), .reset(reset), .start(start_v[0]), .axis_en(axis_en), .params(params),
    .cu_start(cu_start_v[0]), .cu_params(cu_params_v[0]), .cu_finish(cu_finish_v[0]),
    .cu_new_par(cu_new_par_v[0]), .new_par(new_par_v[0]), .busy(busy_v[0]),
    .finish(finish_v[0]), .done(done_v[0]), .axis_done(axis_done_v[0]),
    .axis_err(axis_err_v[0]), .cur_axis(cur_axis_v[0])
  );

  calc_params_scheduler #(.N_AXES(NA), .N_PARAMS(NP), .WIDTH(W),
                          .GAP_CYCLES(0), .TIMEOUT(8)) u_fast (
    .clk(clk), .reset(reset), .start(start_v[1]), .axis_en(axis_en), .params(params),
    .cu_start(cu_start_v[1]), .cu_params(cu_params_v[1]), .cu_finish(cu_finish_v[1]),
    .cu_new_par(cu_new_par_v[1]), .new_par(new_par_v[1]), .busy(busy_v[1]),
    .finish(finish_v[1]), .done(done_v[1]), .axis_done(axis_done_v[1]),
    .axis_err(axis_err_v[1]), .cur_axis(cur_axis_v[1])
  );

  // Calculator model: answers params+1 three cycles after cu_start rises,
  // keeps cu_finish up until cu_start drops plus hold_v extra cycles.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        cu_finish_v[k]  <= 1'b0;
        cu_new_par_v[k] <= '0;
        m_cnt[k]        <= 0;
        m_hold[k]       <= 0;
      end else if (cu_start_v[k]) begin
        m_hold[k] <= hold_v[k];
        if (!(mute_v[k] && (cur_axis_v[k] == mute_ax_v[k]))) begin
          if (m_cnt[k] == 2) begin
            cu_finish_v[k] <= 1'b1;
            for (int i = 0; i < NP; i++) cu_new_par_v[k][i] <= cu_params_v[k][i] + 32'd1;
          end else begin
            m_cnt[k] <= m_cnt[k] + 1;
          end
        end
      end else begin
        m_cnt[k] <= 0;
        if (cu_finish_v[k] && (m_hold[k] != 0)) m_hold[k] <= m_hold[k] - 1;
        else cu_finish_v[k] <= 1'b0;
      end
    end
  end

  typedef struct {
    logic [NA-1:0] en;
    int            mute;
    logic [NA-1:0] exp_done;
    logic [NA-1:0] exp_err;
  } vec_t;
  vec_t tbl [6];

  logic [NA-1:0] r_issued;
  int            r_done_cnt, r_min_low, r_first;
  int            r_hi [NA];
  bit            r_order_ok, r_finished, r_held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_params(input int id);
    for (int a = 0; a < NA; a++)
      for (int i = 0; i < NP; i++)
        params[a][i] = {8'(id), 8'(a), 8'(i), 8'h3C};
  endtask

  task automatic upd_exp(input int k, input logic [NA-1:0] en, input int mute);
    for (int a = 0; a < NA; a++) begin
      if (!en[a]) exp_np[k][a] = params[a];
      else if (a != mute)
        for (int i = 0; i < NP; i++) exp_np[k][a][i] = params[a][i] + 32'd1;
    end
  endtask

  task automatic check_np(input int k);
    for (int a = 0; a < NA; a++)
      for (int i = 0; i < NP; i++)
        chk($sformatf("new_par%0d[%0d][%0d]", k, a, i), 64'(new_par_v[k][a][i]),
            64'(exp_np[k][a][i]));
  endtask

  task automatic run_to_finish(input int k, input logic [NA-1:0] en);
    int low, prev;
    bit prev_start, seen_fall;
    low = 0; prev = -1; prev_start = 1'b0; seen_fall = 1'b0;
    r_issued = '0; r_done_cnt = 0; r_min_low = 1000; r_first = -1;
    r_order_ok = 1'b1; r_finished = 1'b0; r_held = 1'b1;
    for (int a = 0; a < NA; a++) r_hi[a] = 0;
    axis_en    = en;
    start_v[k] = 1'b1;
    for (int c = 0; (c < 3000) && !r_finished; c++) begin
      @(negedge clk);
      if (cu_start_v[k]) begin
        r_hi[int'(cur_axis_v[k])]++;
        if (!prev_start) begin
          if (r_first < 0) r_first = int'(cur_axis_v[k]);
          if (int'(cur_axis_v[k]) <= prev) r_order_ok = 1'b0;
          prev = int'(cur_axis_v[k]);
          r_issued[cur_axis_v[k]] = 1'b1;
          if (seen_fall && (low < r_min_low)) r_min_low = low;
        end
      end else if (prev_start) begin
        seen_fall = 1'b1;
        low = 1;
      end else begin
        low++;
      end
      prev_start = cu_start_v[k];
      if (done_v[k]) r_done_cnt++;
      if (finish_v[k]) r_finished = 1'b1;
    end
    // start stays high: finish must hold and done must not repeat
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!finish_v[k]) r_held = 1'b0;
      if (done_v[k]) r_done_cnt++;
    end
    chk("finished", 64'(r_finished), 64'd1);
    chk("busy_in_done", 64'(busy_v[k]), 64'd0);
    start_v[k] = 1'b0;
    @(negedge clk);
    chk("finish_drop", 64'(finish_v[k]), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    bit found;
    reset = 1'b1; start_v = '0; axis_en = '0; mute_v = '0; mute_ax_v = '0;
    hold_v[0] = 0; hold_v[1] = 0; exp_np = '0;
    set_params(0);

    tbl[0] = '{en: 5'b11111, mute: -1, exp_done: 5'b11111, exp_err: 5'b00000};
    tbl[1] = '{en: 5'b10101, mute: -1, exp_done: 5'b10101, exp_err: 5'b00000};
    tbl[2] = '{en: 5'b11111, mute:  2, exp_done: 5'b11011, exp_err: 5'b00100};
    tbl[3] = '{en: 5'b00010, mute: -1, exp_done: 5'b00010, exp_err: 5'b00000};
    tbl[4] = '{en: 5'b10000, mute: -1, exp_done: 5'b10000, exp_err: 5'b00000};
    tbl[5] = '{en: 5'b01110, mute:  3, exp_done: 5'b00110, exp_err: 5'b01000};

    repeat (3) @(negedge clk);
    chk("rst_cu_start", 64'(cu_start_v), 64'd0);
    chk("rst_busy", 64'(busy_v), 64'd0);
    chk("rst_finish", 64'(finish_v | done_v), 64'd0);
    chk("rst_axis_done", 64'(axis_done_v), 64'd0);
    chk("rst_axis_err", 64'(axis_err_v), 64'd0);
    chk("rst_cur_axis", 64'(cur_axis_v), 64'd0);
    chk("rst_new_par", 64'(new_par_v == '0), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // Slow instance: all axes, 20-cycle gap, 4-cycle handshake per axis
    set_params(1);
    run_to_finish(0, 5'b11111);
    chk("slow_axis_done", 64'(axis_done_v[0]), 64'h1f);
    chk("slow_order", 64'(r_order_ok), 64'd1);
    chk("slow_issued", 64'(r_issued), 64'h1f);
    chk("slow_done_pulses", 64'(r_done_cnt), 64'd1);
    chk("slow_finish_held", 64'(r_held), 64'd1);
    chk("slow_gap_ge20", 64'(r_min_low >= 20), 64'd1);
    for (int a = 0; a < NA; a++) chk($sformatf("slow_hi[%0d]", a), 64'(r_hi[a]), 64'd4);
    upd_exp(0, 5'b11111, -1);
    check_np(0);

    // Abort while axis 1 waits for an answer that never comes
    set_params(2);
    mute_v[0] = 1'b1; mute_ax_v[0] = 3'd1;
    axis_en = 5'b11111; start_v[0] = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cu_start_v[0] && (cur_axis_v[0] == 3'd1)) begin found = 1'b1; break; end
    end
    chk("abort_reach_ax1", 64'(found), 64'd1);
    repeat (3) @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_cu_start", 64'(cu_start_v[0]), 64'd0);
    chk("abort_busy", 64'(busy_v[0]), 64'd0);
    chk("abort_done", 64'(done_v[0] | finish_v[0]), 64'd0);
    chk("abort_axis_done", 64'(axis_done_v[0]), 64'h01);
    chk("abort_axis_err", 64'(axis_err_v[0]), 64'h00);
    for (int i = 0; i < NP; i++) exp_np[0][0][i] = params[0][i] + 32'd1;
    check_np(0);
    mute_v[0] = 1'b0;
    set_params(3);
    run_to_finish(0, 5'b11111);
    chk("rerun_first_axis", 64'(r_first), 64'd0);
    chk("rerun_issued", 64'(r_issued), 64'h1f);
    upd_exp(0, 5'b11111, -1);
    check_np(0);

    // Fast instance: table of enable/timeout patterns
    for (int v = 0; v < 6; v++) begin
      set_params(10 + v);
      mute_v[1]    = (tbl[v].mute >= 0);
      mute_ax_v[1] = AXW'((tbl[v].mute >= 0) ? tbl[v].mute : 0);
      run_to_finish(1, tbl[v].en);
      chk($sformatf("v%0d_axis_done", v), 64'(axis_done_v[1]), 64'(tbl[v].exp_done));
      chk($sformatf("v%0d_axis_err", v), 64'(axis_err_v[1]), 64'(tbl[v].exp_err));
      chk($sformatf("v%0d_issued", v), 64'(r_issued), 64'(tbl[v].en));
      chk($sformatf("v%0d_order", v), 64'(r_order_ok), 64'd1);
      chk($sformatf("v%0d_done_pulses", v), 64'(r_done_cnt), 64'd1);
      chk($sformatf("v%0d_finish_held", v), 64'(r_held), 64'd1);
      if (tbl[v].mute >= 0)
        chk($sformatf("v%0d_timeout_len", v), 64'(r_hi[tbl[v].mute]), 64'd8);
      upd_exp(1, tbl[v].en, tbl[v].mute);
      check_np(1);
    end
    mute_v[1] = 1'b0;

    // No axis enabled: straight to DONE, every set bypassed
    set_params(30);
    axis_en = '0; start_v[1] = 1'b1;
    @(negedge clk);
    chk("none_finish", 64'(finish_v[1]), 64'd1);
    chk("none_done", 64'(done_v[1]), 64'd1);
    chk("none_busy", 64'(busy_v[1]), 64'd0);
    chk("none_cu_start", 64'(cu_start_v[1]), 64'd0);
    @(negedge clk);
    chk("none_done_pulse", 64'(done_v[1]), 64'd0);
    chk("none_finish_hold", 64'(finish_v[1]), 64'd1);
    start_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    upd_exp(1, 5'b00000, -1);
    check_np(1);

    // Calculator keeps cu_finish high 6 extra cycles: next issue must wait
    hold_v[1] = 6;
    set_params(40);
    run_to_finish(1, 5'b11111);
    chk("hold_gap", 64'(r_min_low), 64'd8);
    chk("hold_axis_done", 64'(axis_done_v[1]), 64'h1f);
    upd_exp(1, 5'b11111, -1);
    check_np(1);
    hold_v[1] = 0;

    // Reset in GAP after axis 1 while cu_finish is still high
    hold_v[0] = 10;
    set_params(50);
    axis_en = 5'b11111; start_v[0] = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy_v[0] && !cu_start_v[0] && cu_finish_v[0] && (cur_axis_v[0] == 3'd1)) begin
        found = 1'b1; break;
      end
    end
    chk("gap_reached", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("gaprst_cu_start", 64'(cu_start_v[0]), 64'd0);
    chk("gaprst_busy", 64'(busy_v[0]), 64'd0);
    chk("gaprst_finish", 64'(finish_v[0] | done_v[0]), 64'd0);
    chk("gaprst_axis_done", 64'(axis_done_v[0]), 64'd0);
    chk("gaprst_axis_err", 64'(axis_err_v[0]), 64'd0);
    chk("gaprst_cur_axis", 64'(cur_axis_v[0]), 64'd0);
    chk("gaprst_new_par", 64'(new_par_v[0] == '0), 64'd1);
    chk("gaprst_cu_params", 64'(cu_params_v[0] == '0), 64'd1);
    start_v[0] = 1'b0; hold_v[0] = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 64'(busy_v[0] | cu_start_v[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
